// File: rtl/uart_pkg.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART definitions: receiver FSM state encoding and the
//            default frame geometry used by both the transmitter and receiver.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Default frame geometry (8N1). Both ends of the link must agree.
    localparam int c_CLKS_PER_BIT_DEF = 16;
    localparam int c_DATA_BITS_DEF    = 8;

    // Receiver FSM state encoding (binary).
    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_START = 2'd1;
    localparam logic [1:0] c_ST_DATA  = 2'd2;
    localparam logic [1:0] c_ST_STOP  = 2'd3;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_sipo.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_sipo
// Purpose  : Serial-in / parallel-out shift register. Shifts right with the
//            serial input entering at the MSB, so after WIDTH shifts of an
//            LSB-first stream the first bit received sits in par_out[0].
// Ports    : clk       - system clock
//            rst       - asynchronous active-low clear
//            shift_en  - shift one position this cycle
//            serial_in - bit inserted at the MSB
//            par_out   - current register contents
// Revision : 1.0 - initial release
// ============================================================================
module uart_sipo
    import uart_pkg::*;
#(
    parameter int WIDTH = c_DATA_BITS_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shift_en,
    input  logic             serial_in,
    output logic [WIDTH-1:0] par_out
);

    logic [WIDTH-1:0] r_shift;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_shift <= '0;
        end else if (shift_en) begin
            r_shift <= {serial_in, r_shift[WIDTH-1:1]};
        end
    end

    assign par_out = r_shift;

endmodule : uart_sipo
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : uart_rx
// Purpose  : UART receiver, 8N1, idle-high line. Synchronises rx, detects
//            the start edge, samples each bit at mid-bit, assembles the byte
//            LSB-first and hands it over with a valid/ack handshake.
// Ports    : clk         - system clock
//            rst         - asynchronous active-low reset
//            rx          - asynchronous serial line (idle = 1)
//            data_ack    - one-cycle pulse: consumer took data_out
//            data_out    - last good received byte (bit 0 received first)
//            data_valid  - data_out holds an unacknowledged byte
//            framing_err - one-cycle pulse: stop bit sampled as 0
//            overrun     - sticky: byte completed while data_valid was set
//            busy        - receiver is not idle
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = c_CLKS_PER_BIT_DEF,
    parameter int DATA_BITS    = c_DATA_BITS_DEF
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    input  logic                 data_ack,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 framing_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS);

    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(DATA_BITS - 1);

    // ------------------------------------------------------------------
    // Synchroniser. Flops reset to 1 (idle line) so leaving reset never
    // looks like a start edge.
    // ------------------------------------------------------------------
    logic r_sync1;
    logic r_rx_s;
    logic r_rx_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
        end
    end

    // ------------------------------------------------------------------
    // Receive FSM and counters
    // ------------------------------------------------------------------
    logic [1:0]           r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;

    logic                 w_fall;
    logic                 w_start_tc;
    logic                 w_bit_tc;
    logic                 w_stop_tc;
    logic                 w_byte_done;
    logic                 w_frame_err;
    logic [DATA_BITS-1:0] w_sipo_out;

    // A level-low line is not a start: a 1 -> 0 transition is required.
    assign w_fall      = r_rx_d & ~r_rx_s;
    assign w_start_tc  = (r_state == c_ST_START) && (r_cnt == c_CNT_HALF);
    assign w_bit_tc    = (r_state == c_ST_DATA)  && (r_cnt == c_CNT_LAST);
    assign w_stop_tc   = (r_state == c_ST_STOP)  && (r_cnt == c_CNT_LAST);
    assign w_byte_done = w_stop_tc &  r_rx_s;
    assign w_frame_err = w_stop_tc & ~r_rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_fall) begin
                        r_state <= c_ST_START;
                    end
                end

                // Half a bit period lands the following samples at mid-bit.
                c_ST_START: begin
                    if (w_start_tc) begin
                        r_cnt <= '0;
                        r_idx <= '0;
                        // Line back high at mid-start: treat as a glitch.
                        r_state <= r_rx_s ? c_ST_IDLE : c_ST_DATA;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_DATA: begin
                    if (w_bit_tc) begin
                        r_cnt <= '0;
                        if (r_idx == c_IDX_LAST) begin
                            r_state <= c_ST_STOP;
                            r_idx   <= '0;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                c_ST_STOP: begin
                    if (w_stop_tc) begin
                        r_cnt   <= '0;
                        r_state <= c_ST_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end

                default: begin
                    r_state <= c_ST_IDLE;
                    r_cnt   <= '0;
                    r_idx   <= '0;
                end
            endcase
        end
    end

    assign busy = (r_state != c_ST_IDLE);

    // ------------------------------------------------------------------
    // Data path: one shift per mid-bit sample
    // ------------------------------------------------------------------
    uart_sipo #(
        .WIDTH (DATA_BITS)
    ) u_sipo (
        .clk       (clk),
        .rst       (rst),
        .shift_en  (w_bit_tc),
        .serial_in (r_rx_s),
        .par_out   (w_sipo_out)
    );

    // ------------------------------------------------------------------
    // Output handshake. A byte completing in the same cycle as data_ack
    // replaces the acknowledged one, so it is not an overrun.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_out    <= '0;
            data_valid  <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= w_frame_err;
            if (w_byte_done) begin
                data_out   <= w_sipo_out;
                data_valid <= 1'b1;
                overrun    <= data_ack ? 1'b0 : (overrun | data_valid);
            end else if (data_ack) begin
                data_valid <= 1'b0;
                overrun    <= 1'b0;
            end
        end
    end

endmodule : uart_rx
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_uart_rx
// Purpose  : Self-checking bench for uart_rx. The driver serialises frames
//            onto rx and pushes the expected outcome of each frame (result
//            kind, byte, flags, completion cycle) into a scoreboard queue.
//            A monitor pops an entry whenever busy falls and compares.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int C = 16;
    localparam int H = C / 2;

    localparam int K_GOOD   = 0;
    localparam int K_FERR   = 1;
    localparam int K_GLITCH = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       rx = 1'b1;
    logic       data_ack = 1'b0;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_err;
    logic       overrun;
    logic       busy;

    uart_rx #(
        .CLKS_PER_BIT (C),
        .DATA_BITS    (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx          (rx),
        .data_ack    (data_ack),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         kind;
        logic [7:0] exp_out;
        logic       exp_valid;
        logic       exp_ovr;
        int         end_cyc;
        bit         ack_after;
    } item_t;

    item_t sbq[$];

    int total = 0;
    int bad   = 0;

    // Reference state of the consumer-visible outputs.
    logic [7:0] m_out   = 8'h00;
    logic       m_valid = 1'b0;
    logic       m_ovr   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) tick();
    endtask

    // Expected outcome of a frame whose start edge is driven right after
    // the posedge that brought cyc to k. Completion = 2 sync + 1 edge detect
    // + half bit + 8 data bits + stop bit.
    task automatic push(input int kind, input logic [7:0] b, input bit ack, input int k);
        item_t it;
        it.kind      = kind;
        it.ack_after = ack;
        if (kind == K_GLITCH) it.end_cyc = k + 3 + H;
        else                  it.end_cyc = k + 3 + H + 9 * C;
        if (kind == K_GOOD) begin
            it.exp_ovr   = m_ovr | m_valid;
            it.exp_valid = 1'b1;
            it.exp_out   = b;
            m_out   = b;
            m_valid = 1'b1;
            m_ovr   = it.exp_ovr;
        end else begin
            it.exp_ovr   = m_ovr;
            it.exp_valid = m_valid;
            it.exp_out   = m_out;
        end
        if (ack) begin
            m_valid = 1'b0;
            m_ovr   = 1'b0;
        end
        sbq.push_back(it);
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stopb, input bit ack);
        tick();
        push(stopb ? K_GOOD : K_FERR, b, ack, cyc);
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (C) tick();
        end
        rx = stopb;
        repeat (C) tick();
    endtask

    task automatic glitch();
        tick();
        push(K_GLITCH, 8'h00, 1'b0, cyc);
        rx = 1'b0;
        repeat (3) tick();
        rx = 1'b1;
        repeat (H + 8) tick();
    endtask

    // ------------------------------------------------------------------
    // Monitor: one scoreboard entry per busy falling edge.
    // ------------------------------------------------------------------
    initial begin : monitor
        bit    bprev;
        item_t it;
        bprev = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                bprev = 1'b0;
                continue;
            end
            if (bprev && !busy) begin
                if (sbq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_frame_end actual=busy fell required=no frame (cycle %0d)", cyc);
                end else begin
                    it = sbq.pop_front();
                    chk("end_cycle",   cyc,         it.end_cyc);
                    chk("framing_err", framing_err, (it.kind == K_FERR) ? 1 : 0);
                    chk("data_valid",  data_valid,  it.exp_valid);
                    chk("data_out",    data_out,    it.exp_out);
                    chk("overrun",     overrun,     it.exp_ovr);
                    if (it.kind == K_FERR) begin
                        @(negedge clk);
                        chk("ferr_one_cycle", framing_err, 0);
                    end
                    if (it.ack_after) begin
                        data_ack = 1'b1;
                        @(negedge clk);
                        data_ack = 1'b0;
                        chk("ack_clears_valid",   data_valid, 0);
                        chk("ack_clears_overrun", overrun,    0);
                    end
                end
            end
            bprev = busy;
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    initial begin : stim
        logic [7:0] b;
        bit         sb;
        bit         ak;
        int         gap;

        rst = 1'b0;
        repeat (3) tick();
        chk("rst_data_out",    data_out,    0);
        chk("rst_data_valid",  data_valid,  0);
        chk("rst_framing_err", framing_err, 0);
        chk("rst_overrun",     overrun,     0);
        chk("rst_busy",        busy,        0);
        rst = 1'b1;
        idle(10);

        send_frame(8'hA5, 1'b1, 1'b1);
        idle(5);

        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        idle(5);

        glitch();
        idle(5);

        // Bad stop bit, then line stays low: no new frame may start.
        send_frame(8'h3C, 1'b0, 1'b0);
        rx = 1'b0;
        repeat (2 * C) tick();
        chk("held_low_no_frame", busy, 0);
        idle(5);

        send_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b1);
        idle(5);

        for (int n = 0; n < 8; n++) begin
            b   = 8'($urandom);
            sb  = ($urandom_range(0, 9) != 0);
            ak  = 1'($urandom_range(0, 1));
            gap = sb ? int'($urandom_range(0, 12)) : int'($urandom_range(3, 12));
            send_frame(b, sb, ak);
            idle(gap);
        end
        idle(5);

        // Leave a byte pending, then reset in the middle of data bit 4.
        send_frame(8'h77, 1'b1, 1'b0);
        idle(5);
        b = 8'hC3;
        tick();
        rx = 1'b0;
        repeat (C) tick();
        for (int i = 0; i < 4; i++) begin
            rx = b[i];
            repeat (C) tick();
        end
        rx = b[4];
        repeat (H) tick();
        rst = 1'b0;
        #2;
        chk("midrst_data_out",    data_out,    0);
        chk("midrst_data_valid",  data_valid,  0);
        chk("midrst_framing_err", framing_err, 0);
        chk("midrst_overrun",     overrun,     0);
        chk("midrst_busy",        busy,        0);
        rx = 1'b1;
        m_out   = 8'h00;
        m_valid = 1'b0;
        m_ovr   = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        idle(5);

        send_frame(8'h5A, 1'b1, 1'b1);
        idle(5);

        for (int i = 0; i < 40 * C && sbq.size() != 0; i++) tick();
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL pending_frames actual=%0d required=0", sbq.size());
        end
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_uart_rx
`default_nettype wire

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART receive path. Synchronises the serial line, detects the start bit, and samples each bit at mid-bit. Shifts 8 data bits in LSB-first through a serial-in/parallel-out register, checks the stop bit, and presents the byte with a valid/ack handshake. It is the receive counterpart of the team's transmitter: 8N1 frames, no parity, idle-high line.

Parameters:
CLKS_PER_BIT, 16, clk cycles per bit period; even, >= 4.
DATA_BITS, 8, data bits per frame; fixed at 8 for this release.

Ports:
clk  input  1  system clock.
rst  input  1  asynchronous, active-low reset.
rx  input  1  asynchronous serial line; idle = 1.
data_ack  input  1  consumer has taken data_out; one-cycle pulse.
data_out  output  8  last good received byte; data_out[0] is the first data bit received.
data_valid  output  1  data_out holds an unacknowledged byte.
framing_err  output  1  one-cycle pulse: stop bit sampled as 0.
overrun  output  1  sticky: a byte completed while data_valid was already 1.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0; both synchroniser flops = 1; shift register = 0; counters = 0.
- Synchroniser: rx passes through 2 flops to give rx_s. A third flop holds rx_s_d for falling-edge detection. All decisions use rx_s.
- FSM states: IDLE, START, DATA, STOP. Binary encoded.
- IDLE: on rx_s_d=1 and rx_s=0 (falling edge), go to START and clear the bit counter. A line held low never restarts a frame; a rising edge is required first.
- START: count 0..CLKS_PER_BIT/2-1. At the terminal count, sample rx_s.
  - rx_s=0: go to DATA, clear the counter and bit index.
  - rx_s=1 (glitch): go to IDLE; no outputs change.
- DATA: count 0..CLKS_PER_BIT-1. At the terminal count:
  - shift right, inserting rx_s at the MSB;
  - increment the bit index;
  - after bit index DATA_BITS-1, go to STOP.
- STOP: at terminal count CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: on the next edge, data_out <= shift register and data_valid <= 1. If data_valid was already 1 and data_ack is not asserted this cycle, also set overrun=1; the new byte overwrites the old one. Go to IDLE.
  - rx_s=0: framing_err=1 for exactly one cycle. data_out and data_valid are unchanged. Go to IDLE.
- Latency: data_valid rises 1 cycle after the stop-bit mid-sample. In clk cycles after rx falls, that is 2 (sync) + 1 + CLKS_PER_BIT/2 + DATA_BITS*CLKS_PER_BIT + CLKS_PER_BIT. Exact ±1 alignment is checked in the bench against this formula.
- data_ack clears data_valid and overrun on the next edge. data_ack with data_valid=0 has no effect.
- Simultaneous data_ack and byte completion: the new byte loads, data_valid stays 1, overrun is not set.
- Back-to-back frames: IDLE is entered right after the stop mid-sample. The next start edge is accepted from the following cycle.
- busy = (state != IDLE).
- Reset mid-frame: abort immediately to the reset values; no partial byte and no error is reported.

Decomposition:
- Package uart_pkg holds:
  - the state encoding localparams (IDLE=0, START=1, DATA=2, STOP=3);
  - the default CLKS_PER_BIT and DATA_BITS, shared with the transmitter.
- One sub-module, uart_sipo: 8-bit serial-in/parallel-out register.
  - Ports: clk, rst, shift_en, serial_in, par_out.
  - Shifts right with serial_in entering at the MSB.
  - Async active-low clear.
- The FSM, counters, synchroniser and handshake stay in uart_rx.

Test Plan:
- Single frame 0xA5 (line bits 0,1,0,1,0,0,1,0,1,1) at CLKS_PER_BIT=16 -> data_out=0xA5, data_valid=1 at the computed cycle, framing_err=0, busy falls with data_valid rising.
- Back-to-back 0x00 then 0xFF with no idle gap, data_ack pulsed after each -> two valids in order, values 0x00 and 0xFF, overrun=0.
- 3-cycle low glitch on idle rx -> START aborts to IDLE; data_valid, framing_err and data_out unchanged; busy high for about CLKS_PER_BIT/2 cycles.
- Frame 0x3C with stop bit driven 0 -> one-cycle framing_err; data_valid stays 0. Line held low afterwards -> no new frame until rx returns to 1 and falls again.
- Two frames 0x11 then 0x22 without data_ack -> data_out=0x22, overrun=1. data_ack -> data_valid=0, overrun=0.
- rst asserted in the middle of DATA bit 4 of a frame -> all outputs 0 immediately. The next full frame 0x5A after release is received correctly.
